// File: rtl/text_console_writer.sv
// Writer side of the VGA text buffer: accepts ASCII over valid/ready, tracks the cursor,
// handles control characters, and clears/scrolls the text RAM through its own port.
module text_console_writer #(
  parameter int unsigned COLS = 70,
  parameter int unsigned ROWS = 30
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [15:0] vk_addr,
  output logic        vk_wren,
  output logic [7:0]  vk_wdata,
  input  logic [7:0]  vk_rdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [15:0] LastCell    = 16'(COLS * ROWS - 1);
  localparam logic [15:0] LastRowBase = 16'(COLS * (ROWS - 1));
  localparam logic [15:0] ScrLast     = 16'(COLS * (ROWS - 1) - 1);
  localparam logic [15:0] ColsW       = 16'(COLS);
  localparam logic [6:0]  LastCol     = 7'(COLS - 1);
  localparam logic [4:0]  LastRow     = 5'(ROWS - 1);
  localparam logic [7:0]  Space       = 8'h20;

  typedef enum logic [2:0] {
    StClrAll, StIdle, StWrite, StScrRd, StScrWr, StClrRow
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [15:0] lin_q, lin_d;
  // Cursor to adopt when the pending WRITE retires, so the outputs stay stable while busy.
  logic [4:0]  prow_q, prow_d;
  logic [6:0]  pcol_q, pcol_d;
  logic [15:0] plin_q, plin_d;
  logic        pscroll_q, pscroll_d;
  logic [15:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    lin_d     = lin_q;
    prow_d    = prow_q;
    pcol_d    = pcol_q;
    plin_d    = plin_q;
    pscroll_d = pscroll_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ch_ready  = 1'b0;
    busy      = 1'b1;
    vk_addr   = 16'd0;
    vk_wren   = 1'b0;
    vk_wdata  = 8'd0;

    unique case (state_q)
      StClrAll: begin
        vk_addr  = cnt_q;
        vk_wren  = 1'b1;
        vk_wdata = Space;
        cnt_d    = cnt_q + 16'd1;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
          row_d   = 5'd0;
          col_d   = 7'd0;
          lin_d   = 16'd0;
        end
      end

      StIdle: begin
        ch_ready = 1'b1;
        busy     = 1'b0;
        if (ch_valid) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7e) begin
            state_d   = StWrite;
            waddr_d   = lin_q;
            wdata_d   = ch_data;
            plin_d    = lin_q + 16'd1;
            pscroll_d = 1'b0;
            prow_d    = row_q;
            if (col_q != LastCol) begin
              pcol_d = col_q + 7'd1;
            end else begin
              pcol_d = 7'd0;
              if (row_q == LastRow) pscroll_d = 1'b1;
              else                  prow_d    = row_q + 5'd1;
            end
          end else begin
            case (ch_data)
              8'h0a: begin
                col_d = 7'd0;
                if (row_q == LastRow) begin
                  state_d = StScrRd;
                  cnt_d   = 16'd0;
                  lin_d   = LastRowBase;
                end else begin
                  row_d = row_q + 5'd1;
                  lin_d = lin_q - {9'd0, col_q} + ColsW;
                end
              end
              8'h0d: begin
                col_d = 7'd0;
                lin_d = lin_q - {9'd0, col_q};
              end
              8'h08: begin
                // Both backspace cases land on linear address lin-1.
                if (col_q != 7'd0 || row_q != 5'd0) begin
                  state_d   = StWrite;
                  waddr_d   = lin_q - 16'd1;
                  wdata_d   = Space;
                  plin_d    = lin_q - 16'd1;
                  pscroll_d = 1'b0;
                  if (col_q != 7'd0) begin
                    prow_d = row_q;
                    pcol_d = col_q - 7'd1;
                  end else begin
                    prow_d = row_q - 5'd1;
                    pcol_d = LastCol;
                  end
                end
              end
              8'h0c: begin
                state_d = StClrAll;
                cnt_d   = 16'd0;
              end
              default: ;
            endcase
          end
        end
      end

      StWrite: begin
        vk_addr  = waddr_q;
        vk_wren  = 1'b1;
        vk_wdata = wdata_q;
        if (pscroll_q) begin
          state_d = StScrRd;
          cnt_d   = 16'd0;
          row_d   = LastRow;
          col_d   = 7'd0;
          lin_d   = LastRowBase;
        end else begin
          state_d = StIdle;
          row_d   = prow_q;
          col_d   = pcol_q;
          lin_d   = plin_q;
        end
      end

      StScrRd: begin
        vk_addr = cnt_q + ColsW;
        state_d = StScrWr;
      end

      StScrWr: begin
        vk_addr  = cnt_q;
        vk_wren  = 1'b1;
        vk_wdata = vk_rdata;
        cnt_d    = cnt_q + 16'd1;
        state_d  = (cnt_q == ScrLast) ? StClrRow : StScrRd;
      end

      StClrRow: begin
        vk_addr  = cnt_q;
        vk_wren  = 1'b1;
        vk_wdata = Space;
        cnt_d    = cnt_q + 16'd1;
        if (cnt_q == LastCell) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end
      end

      default: begin
        state_d = StClrAll;
        cnt_d   = 16'd0;
      end
    endcase

    // Reset silences the RAM port in the same cycle it is raised.
    if (rst) begin
      ch_ready = 1'b0;
      busy     = 1'b1;
      vk_addr  = 16'd0;
      vk_wren  = 1'b0;
      vk_wdata = 8'd0;
    end
  end

  assign cursor_row = rst ? 5'd0 : row_q;
  assign cursor_col = rst ? 7'd0 : col_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= StClrAll;
      cnt_q     <= 16'd0;
      row_q     <= 5'd0;
      col_q     <= 7'd0;
      lin_q     <= 16'd0;
      prow_q    <= 5'd0;
      pcol_q    <= 7'd0;
      plin_q    <= 16'd0;
      pscroll_q <= 1'b0;
      waddr_q   <= 16'd0;
      wdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lin_q     <= lin_d;
      prow_q    <= prow_d;
      pcol_q    <= pcol_d;
      plin_q    <= plin_d;
      pscroll_q <= pscroll_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: a RAM model answers the DUT port and a
// screen/cursor reference model predicts contents, cursor and write traffic.
module tb_text_console_writer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int LOGSZ = 16384;

  logic        sys_clk;
  logic        rst;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [15:0] vk_addr;
  logic        vk_wren;
  logic [7:0]  vk_wdata;
  logic [7:0]  vk_rdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .vk_addr    (vk_addr),
    .vk_wren    (vk_wren),
    .vk_wdata   (vk_wdata),
    .vk_rdata   (vk_rdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Text RAM model: synchronous read, read-before-write.
  logic [7:0] mem [CELLS];
  logic       preload = 1'b0;
  always @(posedge sys_clk) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= 8'(i / COLS);
    end else if (vk_wren && int'(vk_addr) < CELLS) begin
      mem[vk_addr] <= vk_wdata;
    end
    if (int'(vk_addr) < CELLS) vk_rdata <= mem[vk_addr];
  end

  // Write monitor, sampled mid-cycle.
  int wr_n = 0;
  int oob = 0;
  int wr_cyc [LOGSZ];
  int wr_addr [LOGSZ];
  int wr_data [LOGSZ];
  always @(negedge sys_clk) begin
    if (vk_wren) begin
      wr_cyc[wr_n % LOGSZ]  <= cyc;
      wr_addr[wr_n % LOGSZ] <= int'(vk_addr);
      wr_data[wr_n % LOGSZ] <= int'(vk_wdata);
      wr_n <= wr_n + 1;
      if (int'(vk_addr) >= CELLS) oob <= oob + 1;
    end
  end

  // Reference model of the screen.
  logic [7:0] exp_mem [CELLS];
  int m_row = 0;
  int m_col = 0;

  task automatic m_clear();
    for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic m_scroll();
    for (int i = 0; i < CELLS - COLS; i++) exp_mem[i] = exp_mem[i + COLS];
    for (int i = CELLS - COLS; i < CELLS; i++) exp_mem[i] = 8'h20;
  endtask

  task automatic m_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7e) begin
      exp_mem[m_row * COLS + m_col] = c;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        if (m_row == ROWS - 1) m_scroll();
        else m_row++;
      end
    end else if (c == 8'h0a) begin
      m_col = 0;
      if (m_row == ROWS - 1) m_scroll();
      else m_row++;
    end else if (c == 8'h0d) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_mem[m_row * COLS + m_col] = 8'h20;
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        exp_mem[m_row * COLS + m_col] = 8'h20;
      end
    end else if (c == 8'h0c) begin
      m_clear();
    end
  endtask

  function automatic int screen_diffs();
    int d = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== exp_mem[i]) d++;
    return d;
  endfunction

  task automatic send_char(input logic [7:0] c, output int acc_cyc);
    int n = 0;
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = c;
    while (!ch_ready && n < 6000) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    if (ch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout: ch_ready=%b after %0d cycles, required 1", ch_ready, n);
    end
    acc_cyc = cyc;
    @(posedge sys_clk);
    #1;
    ch_valid = 1'b0;
    ch_data  = 8'($urandom);
  endtask

  task automatic wait_idle(output int rdy_cyc);
    int n = 0;
    @(negedge sys_clk);
    while (!ch_ready && n < 6000) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    if (ch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_timeout: ch_ready=%b after %0d cycles, required 1", ch_ready, n);
    end
    rdy_cyc = cyc;
  endtask

  // Collects statistics of a full-screen clear that starts in the next cycle.
  task automatic wait_clear(output int nw, output int bad, output int gaps, output int cycles);
    bit started = 0;
    bit ended = 0;
    bit done = 0;
    nw = 0; bad = 0; gaps = 0; cycles = 0;
    while (!done && cycles < 2300) begin
      @(negedge sys_clk);
      cycles++;
      if (ch_ready) begin
        done = 1;
      end else if (vk_wren) begin
        if (ended) gaps++;
        started = 1;
        if (int'(vk_addr) != nw || vk_wdata !== 8'h20) bad++;
        nw++;
      end else if (started) begin
        ended = 1;
      end
    end
  endtask

  task automatic push_char(input logic [7:0] c);
    int a, r;
    send_char(c, a);
    wait_idle(r);
    m_char(c);
  endtask

  task automatic go_to(input int row, input int col);
    if (m_col != 0) push_char(8'h0d);
    while (m_row < row) push_char(8'h0a);
    for (int i = 0; i < col; i++) push_char(8'($urandom_range(33, 126)));
  endtask

  task automatic test_reset();
    int nw, bad, gaps, cycles;
    rst = 1'b1;
    ch_valid = 1'b0;
    ch_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    vectors++;
    if ({vk_wren, vk_addr, vk_wdata, ch_ready, busy, cursor_row, cursor_col} !==
        {1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 5'd0, 7'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: wren=%b addr=%0d wdata=%h ready=%b busy=%b cur=(%0d,%0d), required 0,0,00,0,1,(0,0)",
               vk_wren, vk_addr, vk_wdata, ch_ready, busy, cursor_row, cursor_col);
    end
    @(posedge sys_clk);
    #1 rst = 1'b0;
    wait_clear(nw, bad, gaps, cycles);
    m_clear();
    vectors++;
    if (nw != CELLS || bad != 0 || gaps != 0 || cycles != CELLS + 1) begin
      miscompares++;
      $display("FAIL reset_clear: writes=%0d bad=%0d gaps=%0d idle_cycle=%0d, required %0d,0,0,%0d",
               nw, bad, gaps, cycles, CELLS, CELLS + 1);
    end
    vectors++;
    if (ch_ready !== 1'b1 || busy !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_idle: ready=%b busy=%b cur=(%0d,%0d), required 1,0,(0,0)",
               ch_ready, busy, cursor_row, cursor_col);
    end
    vectors++;
    if (screen_diffs() != 0) begin
      miscompares++;
      $display("FAIL reset_screen: %0d cells differ, required 0", screen_diffs());
    end
  endtask

  task automatic test_back_to_back();
    int acc_c [2];
    int n_acc = 0;
    int base = wr_n;
    int r;
    bit acc;
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    for (int k = 0; k < 20 && n_acc < 2; k++) begin
      acc = ch_ready;
      if (acc) acc_c[n_acc] = cyc;
      @(posedge sys_clk);
      if (acc) begin
        n_acc++;
        #1 ch_data = 8'h42;
      end
      @(negedge sys_clk);
    end
    ch_valid = 1'b0;
    wait_idle(r);
    m_char(8'h41);
    m_char(8'h42);
    vectors++;
    if (n_acc != 2 || acc_c[1] - acc_c[0] != 2) begin
      miscompares++;
      $display("FAIL b2b_accept: accepts=%0d spacing=%0d, required 2,2",
               n_acc, acc_c[1] - acc_c[0]);
    end
    vectors++;
    if (wr_n - base != 2 || wr_addr[base % LOGSZ] != 0 || wr_data[base % LOGSZ] != 'h41 ||
        wr_cyc[base % LOGSZ] != acc_c[0] + 1 || wr_addr[(base + 1) % LOGSZ] != 1 ||
        wr_data[(base + 1) % LOGSZ] != 'h42) begin
      miscompares++;
      $display("FAIL b2b_writes: n=%0d first=%0d:%h@%0d second=%0d:%h, required 2, 0:41@%0d 1:42",
               wr_n - base, wr_addr[base % LOGSZ], wr_data[base % LOGSZ], wr_cyc[base % LOGSZ],
               wr_addr[(base + 1) % LOGSZ], wr_data[(base + 1) % LOGSZ], acc_c[0] + 1);
    end
    vectors++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd2) begin
      miscompares++;
      $display("FAIL b2b_cursor: (%0d,%0d), required (0,2)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_wrap_backspace();
    int a, r, base;
    go_to(5, 69);
    vectors++;
    if (cursor_row !== 5'd5 || cursor_col !== 7'd69) begin
      miscompares++;
      $display("FAIL wrap_setup: (%0d,%0d), required (5,69)", cursor_row, cursor_col);
    end
    base = wr_n;
    send_char(8'h5a, a);
    wait_idle(r);
    m_char(8'h5a);
    vectors++;
    if (wr_n - base != 1 || wr_addr[base % LOGSZ] != 419 || wr_data[base % LOGSZ] != 'h5a ||
        r - a != 2 || cursor_row !== 5'd6 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL wrap_write: n=%0d addr=%0d data=%h lat=%0d cur=(%0d,%0d), required 1,419,5a,2,(6,0)",
               wr_n - base, wr_addr[base % LOGSZ], wr_data[base % LOGSZ], r - a, cursor_row, cursor_col);
    end
    base = wr_n;
    send_char(8'h08, a);
    wait_idle(r);
    m_char(8'h08);
    vectors++;
    if (wr_n - base != 1 || wr_addr[base % LOGSZ] != 419 || wr_data[base % LOGSZ] != 'h20 ||
        cursor_row !== 5'd5 || cursor_col !== 7'd69) begin
      miscompares++;
      $display("FAIL bs_wrap: n=%0d addr=%0d data=%h cur=(%0d,%0d), required 1,419,20,(5,69)",
               wr_n - base, wr_addr[base % LOGSZ], wr_data[base % LOGSZ], cursor_row, cursor_col);
    end
    vectors++;
    if (screen_diffs() != 0) begin
      miscompares++;
      $display("FAIL wrap_screen: %0d cells differ, required 0", screen_diffs());
    end
  endtask

  task automatic test_scroll();
    int a, r, base, bad_cp, bad_cl;
    int idx;
    go_to(29, 10);
    @(negedge sys_clk);
    preload = 1'b1;
    @(posedge sys_clk);
    #1 preload = 1'b0;
    for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'(i / COLS);
    base = wr_n;
    send_char(8'h0a, a);
    wait_idle(r);
    m_char(8'h0a);
    bad_cp = 0;
    bad_cl = 0;
    for (int i = 0; i < CELLS - COLS; i++) begin
      idx = (base + i) % LOGSZ;
      if (wr_addr[idx] != i || wr_data[idx] != i / COLS + 1 || wr_cyc[idx] != a + 2 + 2 * i)
        bad_cp++;
    end
    for (int j = 0; j < COLS; j++) begin
      idx = (base + CELLS - COLS + j) % LOGSZ;
      if (wr_addr[idx] != CELLS - COLS + j || wr_data[idx] != 'h20 ||
          wr_cyc[idx] != a + 2 * (CELLS - COLS) + 1 + j)
        bad_cl++;
    end
    vectors++;
    if (wr_n - base != CELLS || bad_cp != 0 || bad_cl != 0) begin
      miscompares++;
      $display("FAIL scroll_writes: n=%0d bad_copy=%0d bad_clear=%0d, required %0d,0,0",
               wr_n - base, bad_cp, bad_cl, CELLS);
    end
    vectors++;
    if (r - a != 2 * COLS * (ROWS - 1) + COLS + 1) begin
      miscompares++;
      $display("FAIL scroll_busy: ready after %0d cycles, required %0d",
               r - a, 2 * COLS * (ROWS - 1) + COLS + 1);
    end
    vectors++;
    if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL scroll_cursor: (%0d,%0d), required (29,0)", cursor_row, cursor_col);
    end
    vectors++;
    if (screen_diffs() != 0) begin
      miscompares++;
      $display("FAIL scroll_screen: %0d cells differ, required 0", screen_diffs());
    end
  endtask

  task automatic test_noop_chars();
    int a, r, base, nw, bad, gaps, cycles;
    send_char(8'h0c, a);
    wait_clear(nw, bad, gaps, cycles);
    m_char(8'h0c);
    vectors++;
    if (nw != CELLS || bad != 0 || gaps != 0 || cycles != CELLS + 1 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL ff_clear: writes=%0d bad=%0d gaps=%0d idle=%0d cur=(%0d,%0d), required %0d,0,0,%0d,(0,0)",
               nw, bad, gaps, cycles, cursor_row, cursor_col, CELLS, CELLS + 1);
    end
    base = wr_n;
    send_char(8'h08, a);
    wait_idle(r);
    m_char(8'h08);
    vectors++;
    if (wr_n != base || r - a != 1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL bs_origin: writes=%0d lat=%0d cur=(%0d,%0d), required 0,1,(0,0)",
               wr_n - base, r - a, cursor_row, cursor_col);
    end
    send_char(8'h07, a);
    wait_idle(r);
    m_char(8'h07);
    vectors++;
    if (wr_n != base || r - a != 1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL bel_ignored: writes=%0d lat=%0d cur=(%0d,%0d), required 0,1,(0,0)",
               wr_n - base, r - a, cursor_row, cursor_col);
    end
    go_to(3, 40);
    base = wr_n;
    send_char(8'h0d, a);
    wait_idle(r);
    m_char(8'h0d);
    vectors++;
    if (wr_n != base || r - a != 1 || cursor_row !== 5'd3 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL cr: writes=%0d lat=%0d cur=(%0d,%0d), required 0,1,(3,0)",
               wr_n - base, r - a, cursor_row, cursor_col);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [7:0] junk [7];
    int a, r, base, ew, sel;
    junk[0] = 8'h00; junk[1] = 8'h07; junk[2] = 8'h09; junk[3] = 8'h1b;
    junk[4] = 8'h7f; junk[5] = 8'h80; junk[6] = 8'hff;
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      c = 8'($urandom_range(32, 126));
      else if (sel < 78) c = 8'h0a;
      else if (sel < 84) c = 8'h0d;
      else if (sel < 94) c = 8'h08;
      else               c = junk[$urandom_range(0, 6)];
      // Scrolls are covered separately; keep this stream cheap.
      if (m_row == ROWS - 1 && (c == 8'h0a || (c >= 8'h20 && c <= 8'h7e && m_col == COLS - 1)))
        c = 8'h0d;
      ew = ((c >= 8'h20 && c <= 8'h7e) || (c == 8'h08 && (m_row != 0 || m_col != 0))) ? 1 : 0;
      base = wr_n;
      send_char(c, a);
      wait_idle(r);
      m_char(c);
      vectors++;
      if (cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col) || wr_n - base != ew ||
          r - a != 1 + ew) begin
        miscompares++;
        $display("FAIL rand_char[%0d] %h: cur=(%0d,%0d) writes=%0d lat=%0d, required (%0d,%0d),%0d,%0d",
                 k, c, cursor_row, cursor_col, wr_n - base, r - a, m_row, m_col, ew, 1 + ew);
      end
    end
    vectors++;
    if (screen_diffs() != 0) begin
      miscompares++;
      $display("FAIL rand_screen: %0d cells differ, required 0", screen_diffs());
    end
  endtask

  task automatic test_reset_mid_scroll();
    int a, base, nw, bad, gaps, cycles;
    go_to(29, 0);
    send_char(8'h0a, a);
    repeat (500) @(negedge sys_clk);
    @(posedge sys_clk);
    #1 rst = 1'b1;
    base = wr_n;
    @(negedge sys_clk);
    vectors++;
    if (vk_wren !== 1'b0 || busy !== 1'b1 || ch_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_quiet: wren=%b busy=%b ready=%b, required 0,1,0", vk_wren, busy, ch_ready);
    end
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (wr_n != base) begin
      miscompares++;
      $display("FAIL midrst_writes: %0d writes during reset, required 0", wr_n - base);
    end
    @(posedge sys_clk);
    #1 rst = 1'b0;
    wait_clear(nw, bad, gaps, cycles);
    m_clear();
    vectors++;
    if (nw != CELLS || bad != 0 || gaps != 0 || cycles != CELLS + 1 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      miscompares++;
      $display("FAIL midrst_clear: writes=%0d bad=%0d gaps=%0d idle=%0d cur=(%0d,%0d), required %0d,0,0,%0d,(0,0)",
               nw, bad, gaps, cycles, cursor_row, cursor_col, CELLS, CELLS + 1);
    end
    vectors++;
    if (screen_diffs() != 0) begin
      miscompares++;
      $display("FAIL midrst_screen: %0d cells differ, required 0", screen_diffs());
    end
    vectors++;
    if (oob != 0) begin
      miscompares++;
      $display("FAIL addr_range: %0d writes at or above %0d, required 0", oob, CELLS);
    end
  endtask

  initial begin
    rst = 1'b1;
    ch_valid = 1'b0;
    ch_data = 8'h00;
    test_reset();
    test_back_to_back();
    test_wrap_backspace();
    test_scroll();
    test_noop_chars();
    test_random();
    test_reset_mid_scroll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
